// File: rtl/fofb_tf_pkg.sv
// fofb_tf_pkg: mode codes, FSM states and board defaults for the FOFB timeframe generator
package fofb_tf_pkg;
  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_SYNC   = 2'd2,
    MODE_FREE3  = 2'd3
  } tf_mode_e;
  typedef enum logic [2:0] {IDLE, HOLD, RUN, WAIT_SYNC, DONE} tf_state_e;
  localparam int TF_DEF_PERIOD = 10072;
  localparam int TF_DEF_END    = 7500;
  localparam int TF_HOLDOFF    = 10000;
endpackage

// File: rtl/fofb_tf_cfg_shadow.sv
// fofb_tf_cfg_shadow: validates cfg loads, keeps pending and active period/end registers
module fofb_tf_cfg_shadow #(
  parameter int PERIOD_W   = 16,
  parameter int DEF_PERIOD = 10072,
  parameter int DEF_END    = 7500
) (
  input  logic                userclk_i,
  input  logic                sys_reset_n_i,
  input  logic                cfg_load_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
  input  logic [PERIOD_W-1:0] cfg_end_i,
  input  logic                apply_i,
  output logic [PERIOD_W-1:0] period_o,
  output logic [PERIOD_W-1:0] end_o,
  output logic                pend_o,
  output logic                cfg_err_o
);
  logic [PERIOD_W-1:0] pend_period, pend_end;
  logic ok, take;
  assign ok = cfg_period_i >= PERIOD_W'(2) && cfg_end_i != '0 && cfg_end_i < cfg_period_i;
  assign take = cfg_load_i && ok;
  always_ff @(posedge userclk_i)
    if (!sys_reset_n_i) begin
      period_o    <= PERIOD_W'(DEF_PERIOD);
      end_o       <= PERIOD_W'(DEF_END);
      pend_period <= PERIOD_W'(DEF_PERIOD);
      pend_end    <= PERIOD_W'(DEF_END);
      pend_o      <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      cfg_err_o <= cfg_load_i && !ok;
      if (apply_i && pend_o) begin
        period_o <= pend_period;
        end_o    <= pend_end;
      end
      if (take) begin
        pend_period <= cfg_period_i;
        pend_end    <= cfg_end_i;
      end
      pend_o <= take || (pend_o && !apply_i);
    end
endmodule

// File: rtl/fofb_timeframe_gen.sv
// fofb_timeframe_gen: FOFB CC timeframe start/end strobe generator with holdoff, reload and modes
module fofb_timeframe_gen
  import fofb_tf_pkg::*;
#(
  parameter int PERIOD_W   = 16,
  parameter int DEF_PERIOD = TF_DEF_PERIOD,
  parameter int DEF_END    = TF_DEF_END,
  parameter int HOLDOFF    = TF_HOLDOFF,
  parameter int HOLD_W     = 14,
  parameter int CNT_W      = 32
) (
  input  logic                userclk_i,
  input  logic                sys_reset_n_i,
  input  logic                enable_i,
  input  logic [1:0]          mode_i,
  input  logic                ext_sync_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
  input  logic [PERIOD_W-1:0] cfg_end_i,
  input  logic                cfg_load_i,
  output logic                cfg_err_o,
  output logic                timeframe_start_o,
  output logic                timeframe_end_o,
  output logic                frame_active_o,
  output logic                sync_miss_o,
  output logic [CNT_W-1:0]    frame_count_o
);
  tf_state_e state;
  logic [PERIOD_W-1:0] phase, period, end_ph;
  logic [HOLD_W-1:0] hold_cnt;
  logic sync_q, sync_qq, sync_rise, last, first, pend, apply;
  assign sync_rise = sync_q && !sync_qq;
  assign last = phase == period - PERIOD_W'(1);
  assign first = state == RUN && phase == '0;
  assign apply = pend && (state != RUN || last);
  fofb_tf_cfg_shadow #(
    .PERIOD_W  (PERIOD_W),
    .DEF_PERIOD(DEF_PERIOD),
    .DEF_END   (DEF_END)
  ) u_cfg (
    .userclk_i    (userclk_i),
    .sys_reset_n_i(sys_reset_n_i),
    .cfg_load_i   (cfg_load_i),
    .cfg_period_i (cfg_period_i),
    .cfg_end_i    (cfg_end_i),
    .apply_i      (apply),
    .period_o     (period),
    .end_o        (end_ph),
    .pend_o       (pend),
    .cfg_err_o    (cfg_err_o)
  );
  // outputs are a one-cycle registered view of the current state/phase
  always_ff @(posedge userclk_i)
    if (!sys_reset_n_i) begin
      state             <= IDLE;
      phase             <= '0;
      hold_cnt          <= '0;
      sync_q            <= 1'b0;
      sync_qq           <= 1'b0;
      timeframe_start_o <= 1'b0;
      timeframe_end_o   <= 1'b0;
      frame_active_o    <= 1'b0;
      sync_miss_o       <= 1'b0;
      frame_count_o     <= '0;
    end else begin
      sync_q            <= ext_sync_i;
      sync_qq           <= sync_q;
      timeframe_start_o <= first;
      frame_count_o     <= frame_count_o + CNT_W'(first);
      timeframe_end_o   <= state inside {IDLE, HOLD} ? 1'b0 :
                           state != RUN ? timeframe_end_o :
                           phase == end_ph ? 1'b1 :
                           phase == '0 ? 1'b0 : timeframe_end_o;
      frame_active_o    <= state == RUN;
      sync_miss_o       <= sync_rise && mode_i == MODE_SYNC && state inside {IDLE, HOLD, RUN};
      if (!enable_i) state <= IDLE;
      else
        case (state)
          IDLE: begin
            state    <= HOLDOFF == 0 ? RUN : HOLD;
            hold_cnt <= HOLD_W'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
            phase    <= '0;
          end
          HOLD:
            if (hold_cnt == '0) begin
              state <= mode_i == MODE_SYNC ? WAIT_SYNC : RUN;
              phase <= '0;
            end else hold_cnt <= hold_cnt - HOLD_W'(1);
          RUN:
            if (last) begin
              phase <= '0;
              state <= mode_i == MODE_SINGLE ? DONE : mode_i == MODE_SYNC ? WAIT_SYNC : RUN;
            end else phase <= phase + PERIOD_W'(1);
          WAIT_SYNC:
            if (sync_rise) begin
              state <= RUN;
              phase <= '0;
            end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_fofb_timeframe_gen.sv
// tb_fofb_timeframe_gen: directed checks of timing, reload, modes and reset with PERIOD=20, END=15, HOLDOFF=5
module tb_fofb_timeframe_gen;
  logic userclk_i = 1'b0;
  logic sys_reset_n_i, enable_i, ext_sync_i, cfg_load_i;
  logic [1:0] mode_i;
  logic [15:0] cfg_period_i, cfg_end_i;
  logic cfg_err_o, timeframe_start_o, timeframe_end_o, frame_active_o, sync_miss_o;
  logic [31:0] frame_count_o;
  int n, n_cmp, n_err;
  always #5 userclk_i = ~userclk_i;
  fofb_timeframe_gen #(
    .PERIOD_W  (16),
    .DEF_PERIOD(20),
    .DEF_END   (15),
    .HOLDOFF   (5),
    .HOLD_W    (14),
    .CNT_W     (32)
  ) dut (
    .userclk_i        (userclk_i),
    .sys_reset_n_i    (sys_reset_n_i),
    .enable_i         (enable_i),
    .mode_i           (mode_i),
    .ext_sync_i       (ext_sync_i),
    .cfg_period_i     (cfg_period_i),
    .cfg_end_i        (cfg_end_i),
    .cfg_load_i       (cfg_load_i),
    .cfg_err_o        (cfg_err_o),
    .timeframe_start_o(timeframe_start_o),
    .timeframe_end_o  (timeframe_end_o),
    .frame_active_o   (frame_active_o),
    .sync_miss_o      (sync_miss_o),
    .frame_count_o    (frame_count_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask
  task automatic step();
    @(negedge userclk_i);
    n++;
  endtask
  task automatic restart(input logic [1:0] m);
    sys_reset_n_i = 1'b0;
    enable_i      = 1'b0;
    ext_sync_i    = 1'b0;
    cfg_load_i    = 1'b0;
    cfg_period_i  = 16'd20;
    cfg_end_i     = 16'd15;
    mode_i        = m;
    repeat (3) @(negedge userclk_i);
    n = -1;
    chk("rst_start", timeframe_start_o, 0);
    chk("rst_end", timeframe_end_o, 0);
    chk("rst_active", frame_active_o, 0);
    chk("rst_count", frame_count_o, 0);
    chk("rst_err", cfg_err_o, 0);
    sys_reset_n_i = 1'b1;
    enable_i      = 1'b1;
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    n = 0;
    // free-run
    restart(2'd0);
    for (int c = 0; c <= 50; c++) begin
      step();
      chk("t1_start", timeframe_start_o, c == 6 || c == 26 || c == 46);
      chk("t1_end", timeframe_end_o, (c >= 21 && c <= 25) || (c >= 41 && c <= 45));
      chk("t1_active", frame_active_o, c >= 6);
      chk("t1_count", frame_count_o, c < 6 ? 0 : c < 26 ? 1 : c < 46 ? 2 : 3);
    end
    // mid-frame reload takes effect at the next boundary
    restart(2'd0);
    cfg_period_i = 16'd10;
    cfg_end_i    = 16'd3;
    for (int c = 0; c <= 70; c++) begin
      step();
      chk("t2_start", timeframe_start_o, c == 6 || c == 26 || c == 46 || c == 56 || c == 66);
      chk("t2_end", timeframe_end_o, (c >= 21 && c <= 25) || (c >= 41 && c <= 45) ||
                                     (c >= 49 && c <= 55) || (c >= 59 && c <= 65) || c >= 69);
      chk("t2_count", frame_count_o, c < 6 ? 0 : c < 26 ? 1 : c < 46 ? 2 : c < 56 ? 3 : c < 66 ? 4 : 5);
      cfg_load_i = c + 1 == 30;
    end
    // rejected loads, then the end == period-1 boundary accepted
    restart(2'd0);
    for (int c = 0; c <= 47; c++) begin
      step();
      chk("t3_err", cfg_err_o, c == 10 || c == 12 || c == 14);
      chk("t3_start", timeframe_start_o, c == 6 || c == 26 || c == 46);
      chk("t3_end", timeframe_end_o, (c >= 21 && c <= 25) || c == 45);
      cfg_load_i   = (c + 1) inside {10, 12, 14, 16};
      cfg_period_i = c + 1 == 14 ? 16'd1 : 16'd20;
      cfg_end_i    = c + 1 == 10 ? 16'd0 : c + 1 == 12 ? 16'd20 : c + 1 == 14 ? 16'd1 : 16'd19;
    end
    // single-shot, then enable toggle re-arms
    restart(2'd1);
    for (int c = 0; c <= 50; c++) begin
      step();
      chk("t4_start", timeframe_start_o, c == 6 || c == 48);
      chk("t4_end", timeframe_end_o, c >= 21 && c <= 40);
      chk("t4_active", frame_active_o, (c >= 6 && c <= 25) || c >= 48);
      chk("t4_count", frame_count_o, c < 6 ? 0 : c < 48 ? 1 : 2);
      enable_i = !((c + 1) inside {40, 41});
    end
    // external sync with one edge arriving during RUN
    restart(2'd2);
    for (int c = 0; c <= 305; c++) begin
      step();
      chk("t5_start", timeframe_start_o, c == 102 || c == 302);
      chk("t5_miss", sync_miss_o, c == 111);
      chk("t5_active", frame_active_o, (c >= 102 && c <= 121) || c >= 302);
      chk("t5_end", timeframe_end_o, c >= 117 && c <= 301);
      chk("t5_count", frame_count_o, c < 102 ? 0 : c < 302 ? 1 : 2);
      ext_sync_i = (c + 1) inside {[100:103], [110:111], [300:301]};
    end
    // disable holds the count, reset clears it and restores the default cfg
    restart(2'd0);
    cfg_period_i = 16'd10;
    cfg_end_i    = 16'd3;
    for (int c = 0; c <= 70; c++) begin
      step();
      chk("t6_start", timeframe_start_o, c == 6 || c == 26 || c == 47 || c == 67);
      chk("t6_end", timeframe_end_o, (c >= 21 && c <= 25) || (c >= 62 && c <= 66));
      chk("t6_active", frame_active_o, (c >= 6 && c <= 35) || c >= 47);
      chk("t6_count", frame_count_o, c < 6 ? 0 : c < 26 ? 1 : c < 40 ? 2 : c < 47 ? 0 : c < 67 ? 1 : 2);
      enable_i      = c + 1 < 35 || c + 1 >= 41;
      cfg_load_i    = c + 1 == 30;
      sys_reset_n_i = c + 1 != 40;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
